// File: rtl/quadratic_arbiter_pkg.sv
// Shared rtx datapath types and latencies for the quadratic solver path.
// fp24 is signed fixed point with 12 integer and 12 fraction bits.
package quadratic_arbiter_pkg;

    typedef logic [23:0] fp24;

    localparam int SQRT_DELAY      = 12;
    localparam int SQRT_STEPS      = 24 / SQRT_DELAY;
    localparam int QR_SOLVER_DELAY = 16;
    localparam int QR_ARB_LATENCY  = QR_SOLVER_DELAY + 2;
    localparam int CREDIT_W        = 4;

    typedef struct packed {
        logic [25:0] rem;
        logic [23:0] root;
        logic [47:0] rad;
        fp24         b;
        logic        ok;
    } sqrt_t;

    // One restoring square-root step: consumes the top two radicand bits.
    function automatic sqrt_t sqrt_step(sqrt_t s);
        sqrt_t       n;
        logic [25:0] r;
        logic [25:0] t;
        n     = s;
        r     = {s.rem[23:0], s.rad[47:46]};
        t     = {s.root, 2'b01};
        n.rad = {s.rad[45:0], 2'b00};
        if (r >= t) begin
            n.rem  = r - t;
            n.root = {s.root[22:0], 1'b1};
        end else begin
            n.rem  = r;
            n.root = {s.root[22:0], 1'b0};
        end
        return n;
    endfunction

    function automatic sqrt_t sqrt_stage(sqrt_t s);
        sqrt_t n;
        n = s;
        for (int i = 0; i < SQRT_STEPS; i++) begin
            n = sqrt_step(n);
        end
        return n;
    endfunction

endpackage

// File: rtl/quadratic_arbiter_if.sv
// Request/result bundle between ray-traversal units and the solver arbiter.
interface quadratic_arbiter_if #(
    parameter int N_REQ = 4
);
    import quadratic_arbiter_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    fp24  [N_REQ-1:0] req_b;
    fp24  [N_REQ-1:0] req_c;
    logic             res_valid;
    logic [ID_W-1:0]  res_id;
    fp24              res_x0;
    logic             res_real;

    modport master (
        output req_valid, req_b, req_c,
        input  req_ready, res_valid, res_id, res_x0, res_real
    );

    modport slave (
        input  req_valid, req_b, req_c,
        output req_ready, res_valid, res_id, res_x0, res_real
    );

endinterface

// File: rtl/pipeline.sv
// Fixed-depth delay line with synchronous clear.
module pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/quadratic_solver.sv
// Fully pipelined x0 = (-b - sqrt(b*b - 4c)) / 2 on fp24 operands.
module quadratic_solver
    import quadratic_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  fp24  b,
    input  fp24  c,
    output fp24  x0,
    output logic valid
);

    localparam int PAD = QR_SOLVER_DELAY - SQRT_DELAY - 2;

    logic signed [47:0] bb;
    logic signed [47:0] disc;
    logic signed [25:0] t;
    sqrt_t              head;
    sqrt_t              sq [SQRT_DELAY+1];
    fp24                x0_r;
    logic               ok_r;
    logic [24:0]        pad_q;

    // Discriminant in Q.24; its square root lands back in Q.12.
    always_comb begin
        bb        = $signed(b) * $signed(b);
        disc      = bb - {{10{c[23]}}, c, 14'b0};
        head      = '0;
        head.rad  = disc[47] ? '0 : disc;
        head.b    = b;
        head.ok   = !disc[47];
    end

    assign t = -{{2{sq[SQRT_DELAY].b[23]}}, sq[SQRT_DELAY].b}
             - {2'b00, sq[SQRT_DELAY].root};

    always_ff @(posedge clk) begin
        sq[0] <= head;
        for (int i = 0; i < SQRT_DELAY; i++) begin
            sq[i+1] <= sqrt_stage(sq[i]);
        end
        x0_r <= 24'(t >>> 1);
        ok_r <= sq[SQRT_DELAY].ok;
    end

    pipeline #(
        .WIDTH (25),
        .DEPTH (PAD)
    ) u_pad (
        .clk (clk),
        .rst (rst),
        .d   ({x0_r, ok_r}),
        .q   (pad_q)
    );

    assign {x0, valid} = pad_q;

endmodule

// File: rtl/quadratic_arbiter.sv
// Round-robin, credit-limited sharing of one quadratic_solver between
// N_REQ requesters; the owner id rides a tag pipe matched to the solver.
module quadratic_arbiter
    import quadratic_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input logic               clk,
    input logic               rst,
    quadratic_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    typedef logic [ID_W-1:0] id_t;

    logic [CREDIT_W-1:0] credit [N_REQ];
    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    ret;
    id_t                 last;
    id_t                 pick;
    id_t                 cand;
    logic                found;

    logic iss_valid;
    id_t  iss_id;
    fp24  iss_b;
    fp24  iss_c;
    fp24  sol_x0;
    logic sol_real;
    logic tag_valid;
    id_t  tag_id;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_valid[i]
                   && (credit[i] < CREDIT_W'(MAX_INFLIGHT));
            ret[i]  = bus.res_valid && (bus.res_id == id_t'(i));
        end
    end

    // Search starts just after the last winner and wraps.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = '0;
        grant = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = id_t'((int'(last) + k) % N_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        if (found && !rst) begin
            grant[pick] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= id_t'(N_REQ - 1);
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_b     <= '0;
            iss_c     <= '0;
        end else begin
            iss_valid <= found;
            iss_id    <= pick;
            iss_b     <= found ? bus.req_b[pick] : '0;
            iss_c     <= found ? bus.req_c[pick] : '0;
            if (found) begin
                last <= pick;
            end
        end
    end

    quadratic_solver u_solver (
        .clk   (clk),
        .rst   (rst),
        .b     (iss_b),
        .c     (iss_c),
        .x0    (sol_x0),
        .valid (sol_real)
    );

    pipeline #(
        .WIDTH (1 + ID_W),
        .DEPTH (QR_SOLVER_DELAY)
    ) u_tag (
        .clk (clk),
        .rst (rst),
        .d   ({iss_valid, iss_id}),
        .q   ({tag_valid, tag_id})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_x0    <= '0;
            bus.res_real  <= 1'b0;
        end else begin
            bus.res_valid <= tag_valid;
            if (tag_valid) begin
                bus.res_id   <= tag_id;
                bus.res_x0   <= sol_x0;
                bus.res_real <= sol_real;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst) begin
                credit[i] <= '0;
            end else begin
                case ({grant[i], ret[i]})
                    2'b10:   credit[i] <= credit[i] + 1'b1;
                    2'b01:   credit[i] <= credit[i] - 1'b1;
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

endmodule
